sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (0 = character, 1 = obstacle, 2 = HUD).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, sprite ROM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 12, sprite ROM pixel width (RGB444).
REQ-004 SHALL have parameter ROM_LATENCY, default 2, cycles from rom_en to valid rom_data (range 1..4).
REQ-005 SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse at frame start.
REQ-008 SHALL have port req  input  N_REQ  per-requester read request, level.
REQ-009 SHALL have port req_addr  input  N_REQ*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port gnt  output  N_REQ  one-hot grant, combinational, same cycle as the winning req.
REQ-011 SHALL have port rom_en  output  1  registered ROM read enable.
REQ-012 SHALL have port rom_addr  output  ADDR_WIDTH  registered ROM address.
REQ-013 SHALL have port rom_data  input  DATA_WIDTH  ROM read data.
REQ-014 SHALL have port rd_valid  output  N_REQ  one-hot return strobe, registered.
REQ-015 SHALL have port rd_data  output  DATA_WIDTH  returned pixel, registered.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt is all-zero when req is all-zero.
REQ-017 SHALL arbitrate round-robin: the search starts at priority pointer ptr and proceeds ptr, ptr+1, ..., wrapping modulo N_REQ; the first requester with req=1 wins.
REQ-018 SHALL, on a grant to index i, load ptr <= (i+1) mod N_REQ on the next edge; with no grant, ptr is unchanged.
REQ-019 SHALL force ptr <= 0 on the edge following frame_tick=1, overriding REQ-018 when both occur in the same cycle; the grant in that cycle is still issued.
REQ-020 SHALL, for a grant to i in cycle T, drive rom_en=1 and rom_addr=req_addr[i] in cycle T+1; in cycles with no grant, rom_en=0 and rom_addr holds its previous value.
REQ-021 SHALL carry the granted index through a ROM_LATENCY-deep valid/tag pipeline and, in cycle T+1+ROM_LATENCY, assert rd_valid[i]=1 for exactly one cycle, with rd_data = rom_data sampled at that edge.
REQ-022 SHALL sustain one grant per cycle; back-to-back grants yield back-to-back rd_valid pulses in grant order with no gaps or reordering.
REQ-023 SHALL hold rd_data at its last value when rd_valid is all-zero.
REQ-024 SHALL rely on the requester to hold req and req_addr stable until gnt; a requester may change req_addr or drop req in the cycle after gnt; gnt does not depend on rom_data.
REQ-025 SHALL treat index arithmetic as unsigned, of width $clog2(N_REQ), with explicit wrap at N_REQ-1 -> 0 (not power-of-two overflow).

Reset
REQ-026 SHALL, while sys_rst_n=0, asynchronously clear ptr=0, rom_en=0, rom_addr=0, rd_valid=0, rd_data=0, and the whole tag/valid pipeline.
REQ-027 SHALL drop in-flight reads on reset mid-operation: no rd_valid pulse appears after release for grants issued before reset.
REQ-028 SHALL hold gnt=0 while sys_rst_n=0, regardless of req.

Verification
REQ-029 SHALL pass: req=3'b111 held for 6 cycles after reset -> gnt sequence 001,010,100,001,010,100; rd_valid is the same sequence delayed by 3 cycles (ROM_LATENCY=2).
REQ-030 SHALL pass: req=3'b010 alone with addr 0x0123 in cycle T -> gnt=010 in T, rom_en=1 with rom_addr=0x0123 in T+1, rd_valid=010 with rd_data=ROM[0x0123] in T+3.
REQ-031 SHALL pass: ptr=2 with frame_tick and req=3'b011 in the same cycle -> grant goes to 0 (wrap from 2), ptr=0 on the next cycle; req=3'b011 then grants 0 again.
REQ-032 SHALL pass: req=0 for 10 cycles -> gnt=0, rom_en=0, rd_valid=0, ptr unchanged, rd_data held.
REQ-033 SHALL pass: sys_rst_n pulsed low 1 cycle after two grants -> all outputs 0 immediately; no rd_valid after release until a new grant plus 3 cycles.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM between several pixel requesters.
// Grants are combinational; the winner's address is registered to the ROM and a tag pipeline routes the pixel back.
module sprite_rom_arbiter #(
    parameter int N_REQ       = 3,
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 12,
    parameter int ROM_LATENCY = 2
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        frame_tick,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            gnt,
    output logic                        rom_en,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [DATA_WIDTH-1:0]       rom_data,
    output logic [N_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]                    ptr_reg;
    logic [IDX_W-1:0]                    ptr_next;
    logic [IDX_W-1:0]                    win_idx;
    logic [IDX_W-1:0]                    cand_idx;
    logic                                win_found;
    logic [N_REQ-1:0]                    gnt_vec;
    int                                  cand;

    logic [ROM_LATENCY-1:0]              vld_pipe_reg;
    logic [ROM_LATENCY-1:0][IDX_W-1:0]   tag_pipe_reg;
    logic [ADDR_WIDTH-1:0]               rom_addr_reg;
    logic [N_REQ-1:0]                    rd_valid_reg;
    logic [DATA_WIDTH-1:0]               rd_data_reg;
    logic [N_REQ-1:0]                    tag_onehot;

    // Search ptr, ptr+1, ... with explicit wrap so non-power-of-two N_REQ never visits an unused index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        cand      = 0;
        gnt_vec   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_reg) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        if (!sys_rst_n) win_found = 1'b0;
        if (win_found) gnt_vec[win_idx] = 1'b1;
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (frame_tick)
            ptr_next = '0;
        else if (win_found)
            ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign tag_onehot[gi] = (tag_pipe_reg[ROM_LATENCY-1] == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr_reg      <= '0;
            vld_pipe_reg <= '0;
            tag_pipe_reg <= '0;
            rom_addr_reg <= '0;
            rd_valid_reg <= '0;
            rd_data_reg  <= '0;
        end else begin
            ptr_reg         <= ptr_next;
            vld_pipe_reg[0] <= win_found;
            tag_pipe_reg[0] <= win_idx;
            if (win_found)
                rom_addr_reg <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            for (int s = 1; s < ROM_LATENCY; s++) begin
                vld_pipe_reg[s] <= vld_pipe_reg[s-1];
                tag_pipe_reg[s] <= tag_pipe_reg[s-1];
            end
            rd_valid_reg <= vld_pipe_reg[ROM_LATENCY-1] ? tag_onehot : '0;
            if (vld_pipe_reg[ROM_LATENCY-1])
                rd_data_reg <= rom_data;
        end
    end

    assign gnt      = gnt_vec;
    assign rom_en   = vld_pipe_reg[0];
    assign rom_addr = rom_addr_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: the driver checks grants and queues the expected ROM
// accesses and pixel returns; independent monitors pop and compare them as the DUT emits them.
module tb_sprite_rom_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [2:0]  req = '0;
    logic [41:0] req_addr = '0;
    logic [2:0]  gnt;
    logic        rom_en;
    logic [13:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [2:0]  rd_valid;
    logic [11:0] rd_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { logic [2:0] onehot; logic [11:0] data; int due; } rd_exp_t;
    typedef struct { logic [13:0] addr; int due; } rom_exp_t;
    rd_exp_t  rd_q[$];
    rom_exp_t rom_q[$];
    logic [11:0] last_data = '0;
    logic [13:0] last_addr = '0;

    sprite_rom_arbiter dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .frame_tick (frame_tick),
        .req        (req),
        .req_addr   (req_addr),
        .gnt        (gnt),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [11:0] rom_f(input logic [13:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    // One-cycle synchronous ROM: data for the address presented with rom_en appears the next cycle.
    always @(posedge sys_clk) rom_data <= rom_f(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic [2:0] r, input logic [13:0] a0, input logic [13:0] a1,
                        input logic [13:0] a2, input logic ft, input logic [2:0] exp);
        logic [13:0] sel;
        req = r;
        req_addr = {a2, a1, a0};
        frame_tick = ft;
        @(negedge sys_clk);
        chk("gnt", {29'd0, gnt}, {29'd0, exp});
        if (exp != 3'b000) begin
            sel = exp[0] ? a0 : (exp[1] ? a1 : a2);
            rom_q.push_back('{sel, cyc + 1});
            rd_q.push_back('{exp, rom_f(sel), cyc + 3});
            $display("cycle %0d req=%b ft=%b gnt=%b addr=%h", cyc, r, ft, gnt, sel);
        end else begin
            $display("cycle %0d req=%b ft=%b gnt=%b idle", cyc, r, ft, gnt);
        end
        @(posedge sys_clk);
        #1;
        frame_tick = 1'b0;
    endtask

    // Pixel return monitor.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            last_data = '0;
        end else if (rd_valid != 3'b000) begin
            if (rd_q.size() == 0) begin
                chk("rd_valid_unexpected", {29'd0, rd_valid}, 32'd0);
            end else begin
                chk("rd_valid", {29'd0, rd_valid}, {29'd0, rd_q[0].onehot});
                chk("rd_data", {20'd0, rd_data}, {20'd0, rd_q[0].data});
                chk("rd_cycle", cyc, rd_q[0].due);
                last_data = rd_q[0].data;
                void'(rd_q.pop_front());
            end
        end else begin
            if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
                chk("rd_valid_missing", 32'd0, {29'd0, rd_q[0].onehot});
                void'(rd_q.pop_front());
            end
            chk("rd_data_hold", {20'd0, rd_data}, {20'd0, last_data});
        end
    end

    // ROM request monitor.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            last_addr = '0;
        end else if (rom_en) begin
            if (rom_q.size() == 0) begin
                chk("rom_en_unexpected", 32'd1, 32'd0);
            end else begin
                chk("rom_addr", {18'd0, rom_addr}, {18'd0, rom_q[0].addr});
                chk("rom_cycle", cyc, rom_q[0].due);
                last_addr = rom_q[0].addr;
                void'(rom_q.pop_front());
            end
        end else begin
            if (rom_q.size() != 0 && rom_q[0].due <= cyc) begin
                chk("rom_en_missing", 32'd0, 32'd1);
                void'(rom_q.pop_front());
            end
            chk("rom_addr_hold", {18'd0, rom_addr}, {18'd0, last_addr});
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"}, {29'd0, gnt}, 32'd0);
        chk({tag, "_rom_en"}, {31'd0, rom_en}, 32'd0);
        chk({tag, "_rom_addr"}, {18'd0, rom_addr}, 32'd0);
        chk({tag, "_rd_valid"}, {29'd0, rd_valid}, 32'd0);
        chk({tag, "_rd_data"}, {20'd0, rd_data}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with all requesters asserted to show gnt is gated.
        req = 3'b111;
        repeat (2) @(posedge sys_clk);
        #1;
        chk_outputs_zero("reset");
        req = 3'b000;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Full contention rotates 0,1,2.
        step(3'b111, 14'h0010, 14'h0020, 14'h0030, 1'b0, 3'b001);
        step(3'b111, 14'h0011, 14'h0021, 14'h0031, 1'b0, 3'b010);
        step(3'b111, 14'h0012, 14'h0022, 14'h0032, 1'b0, 3'b100);
        step(3'b111, 14'h0013, 14'h0023, 14'h0033, 1'b0, 3'b001);
        step(3'b111, 14'h0014, 14'h0024, 14'h0034, 1'b0, 3'b010);
        step(3'b111, 14'h0015, 14'h0025, 14'h0035, 1'b0, 3'b100);

        // Single obstacle request; ptr then points at 2.
        step(3'b010, 14'h0000, 14'h0123, 14'h0000, 1'b0, 3'b010);

        // Ten idle cycles: nothing moves, rd_data and rom_addr hold.
        for (int i = 0; i < 10; i++) step(3'b000, 14'h0, 14'h0, 14'h0, 1'b0, 3'b000);

        // ptr=2: wrap-around grant to 0 while frame_tick forces ptr back to 0.
        step(3'b011, 14'h0100, 14'h0200, 14'h0300, 1'b1, 3'b001);
        step(3'b011, 14'h0101, 14'h0201, 14'h0301, 1'b0, 3'b001);
        step(3'b011, 14'h0102, 14'h0202, 14'h0302, 1'b0, 3'b010);
        step(3'b101, 14'h0103, 14'h0203, 14'h0303, 1'b0, 3'b100);
        step(3'b100, 14'h0104, 14'h0204, 14'h3FFF, 1'b0, 3'b100);
        step(3'b110, 14'h0105, 14'h2ABC, 14'h0305, 1'b0, 3'b010);
        step(3'b000, 14'h0000, 14'h0000, 14'h0000, 1'b1, 3'b000);
        step(3'b110, 14'h0106, 14'h0206, 14'h0306, 1'b0, 3'b010);

        // Two grants, then an asynchronous reset pulse with reads still in flight.
        step(3'b111, 14'h0400, 14'h0500, 14'h0600, 1'b0, 3'b100);
        step(3'b111, 14'h0401, 14'h0501, 14'h0601, 1'b0, 3'b001);
        sys_rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        rd_q.delete();
        rom_q.delete();
        @(posedge sys_clk);
        #1;
        req = 3'b000;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(3'b000, 14'h0, 14'h0, 14'h0, 1'b0, 3'b000);
        step(3'b011, 14'h0777, 14'h0888, 14'h0999, 1'b0, 3'b001);

        // Drain and confirm nothing is left outstanding.
        for (int i = 0; i < 6; i++) step(3'b000, 14'h0, 14'h0, 14'h0, 1'b0, 3'b000);
        chk("rd_queue_empty", rd_q.size(), 32'd0);
        chk("rom_queue_empty", rom_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
